noekeon_gamma_iter: RTL
=======================

# noekeon_gamma_iter

Iterative, parametrised Noekeon Gamma engine that applies the 4-bit Gamma S-box to all 32 bit-slice columns of a 128-bit Noekeon state, LANES columns per clock. It sits between the Theta/Pi1 stage and the Pi2 stage of the round datapath and trades area for latency via LANES. Data moves on valid/ready handshakes on both sides, so the round controller can stall it freely.

## Interface
Parameters:
- LANES, 4: S-box lanes evaluated per cycle; legal values 1, 2, 4, 8, 16, 32; any other value is an elaboration error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input state valid.
- in_ready  out  1  engine can accept a state.
- in_data  in  128  input state; in_data[32k+31:32k] = word a_k, k=0..3.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  128  Gamma(in_data), same word layout.
- busy  out  1  high while in BUSY state.

## Operation
- Column i (0..31) nibble = {a3[i], a2[i], a1[i], a0[i]}; it is replaced by SBOX[nibble], SBOX = 7,A,2,C,4,8,F,0,5,9,1,E,3,D,B,6 for inputs 0..F.
- STEPS = 32/LANES.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid: load in_data into state register, clear step counter, go to BUSY.
  - BUSY: each cycle, substitute columns [LANES-1:0] of every word, then rotate each word right by LANES (mod 32). After STEPS cycles the columns are back in original positions; go to DONE.
  - DONE: out_valid=1, out_data = state register. On out_ready: go to IDLE (base build).
- Step counter width clog2(STEPS)+1; wraps never reached, terminal count STEPS-1.
- out_data held stable while out_valid=1 and out_ready=0.
- in_valid outside IDLE (base build) is ignored; in_data is not sampled.
- Gamma is an involution: two passes return the original state.

## Timing
- Reset (async assert, sync release): state IDLE, state register 0, counter 0, in_ready=1, out_valid=0, busy=0, out_data=0.
- Capture at edge E0 (in_valid & in_ready); out_valid rises after edge E_STEPS, i.e. STEPS cycles after capture. LANES=32 gives 1 cycle.
- Base throughput: one state per STEPS+2 cycles with out_ready held high (capture, STEPS steps, DONE handshake returns to IDLE).
- Reset asserted mid-BUSY or in DONE: operation abandoned, no out_valid; outputs take reset values immediately.
- in_ready and out_valid are registered-state decodes only, no combinational path from in_valid/out_ready.

## Configuration
- NOEKEON_GAMMA_SKID_EN defined: one 128-bit input holding buffer added. in_ready=1 in BUSY and DONE while buffer empty; captured state waits in buffer. On DONE out handshake, if buffer full, load buffer directly into state register and go to BUSY (skip IDLE); back-to-back throughput one state per STEPS+1 cycles. Buffer cleared by reset.
- Not defined: no buffer, in_ready=1 only in IDLE, behaviour as above.

## Structure
- Package noekeon_pkg: SBOX constant array (16 x 4 bit), WORD_W=32, STATE_W=128, FSM state enum, LANES legality check function.
- Sub-module noekeon_gamma_lane: combinational 4-bit S-box from the package table, instantiated LANES times via generate.

## Test plan
- Reset check: rst_n low mid-BUSY -> in_ready=1, out_valid=0, busy=0, out_data=0 next cycle and after release.
- All-zero state, LANES=4 -> out_valid after 8 cycles, out_data=128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF.
- All-ones state, LANES=1 and LANES=32 -> out_data=128'h00000000_FFFFFFFF_FFFFFFFF_00000000 after 32 and 1 cycles respectively.
- Random states, each legal LANES -> match bit-slice golden model; feeding result back in returns the original state.
- out_ready held low 10 cycles in DONE -> out_data stable, in_valid ignored (base) / accepted once then in_ready=0 (SKID_EN).
- SKID_EN, continuous in_valid and out_ready, LANES=8 -> a result every 5 cycles, no state lost or duplicated.

Source files
------------

// File: rtl/noekeon_pkg.sv
// Shared definitions for the iterative Noekeon Gamma engine: word and state
// widths, the Gamma S-box table, the engine FSM encoding and the lane-count
// legality check used at elaboration.
package noekeon_pkg;

  localparam int WORD_W  = 32;
  localparam int STATE_W = 128;
  localparam int NIB_W   = 4;

  // Gamma S-box, indexed by the column nibble {a3[i], a2[i], a1[i], a0[i]}.
  localparam logic [NIB_W-1:0] SBOX [16] = '{
    4'h7, 4'hA, 4'h2, 4'hC, 4'h4, 4'h8, 4'hF, 4'h0,
    4'h5, 4'h9, 4'h1, 4'hE, 4'h3, 4'hD, 4'hB, 4'h6
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } gamma_state_e;

  // LANES must divide the 32 columns into a power-of-two number of steps.
  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) ||
           (lanes == 8) || (lanes == 16) || (lanes == 32);
  endfunction

endpackage

// File: rtl/noekeon_gamma_lane.sv
// One Gamma S-box lane: pure table lookup of a 4-bit column nibble.
module noekeon_gamma_lane
  import noekeon_pkg::*;
(
  input  logic [NIB_W-1:0] nib_in,
  output logic [NIB_W-1:0] nib_out
);

  assign nib_out = SBOX[nib_in];

endmodule

// File: rtl/noekeon_gamma_iter.sv
// Iterative Noekeon Gamma engine. Each BUSY cycle substitutes the low LANES
// columns of the 128-bit state and rotates every word right by LANES, so
// after 32/LANES steps every column has been substituted exactly once and is
// back in its original position.
//
// Optional build macro NOEKEON_GAMMA_SKID_EN adds a one-entry input holding
// buffer so the next state can be accepted while the current one is being
// processed or waiting to be taken.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid/data are held by the producer until that edge, and
// in_ready/out_valid are pure decodes of registered state (no combinational
// path from in_valid or out_ready).
module noekeon_gamma_iter
  import noekeon_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy
);

  localparam int STEPS = WORD_W / LANES;
  localparam int CNT_W = $clog2(STEPS) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("noekeon_gamma_iter: LANES must be 1, 2, 4, 8, 16 or 32");
  end

  gamma_state_e       st_q, st_d;
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] step_data;
  logic [CNT_W-1:0]   cnt_q;
  logic               load_in;
  logic               do_step;

`ifdef NOEKEON_GAMMA_SKID_EN
  logic               load_buf;
  logic               buf_push;
  logic               buf_full_q;
  logic [STATE_W-1:0] buf_q;
`endif

  // ---------------------------------------------------------------------------
  // One step of the datapath: S-box on columns [LANES-1:0], then rotate right.
  // ---------------------------------------------------------------------------
  logic [NIB_W-1:0] lane_in  [LANES];
  logic [NIB_W-1:0] lane_out [LANES];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign lane_in[j] = {state_q[3*WORD_W+j], state_q[2*WORD_W+j],
                         state_q[WORD_W+j], state_q[j]};
    noekeon_gamma_lane u_lane (
      .nib_in  (lane_in[j]),
      .nib_out (lane_out[j])
    );
  end

  for (genvar k = 0; k < 4; k++) begin : g_word
    logic [WORD_W-1:0]   sub_w;
    logic [2*WORD_W-1:0] dbl_w;

    // Replace the low LANES columns of word k with bit k of each lane result.
    always_comb begin
      sub_w = state_q[WORD_W*k +: WORD_W];
      for (int j = 0; j < LANES; j++) begin
        sub_w[j] = lane_out[j][k];
      end
    end

    // Rotate right by LANES via a doubled word; LANES=32 degenerates to identity.
    assign dbl_w = {sub_w, sub_w};
    assign step_data[WORD_W*k +: WORD_W] = dbl_w[LANES+WORD_W-1:LANES];
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= ST_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // Next-state decode and datapath control strobes.
  always_comb begin
    st_d    = st_q;
    load_in = 1'b0;
    do_step = 1'b0;
`ifdef NOEKEON_GAMMA_SKID_EN
    load_buf = 1'b0;
    buf_push = 1'b0;
`endif
    case (st_q)
      ST_IDLE: begin
        if (in_valid) begin
          st_d    = ST_BUSY;
          load_in = 1'b1;
        end
      end
      ST_BUSY: begin
        do_step = 1'b1;
`ifdef NOEKEON_GAMMA_SKID_EN
        buf_push = in_valid && !buf_full_q;
`endif
        if (cnt_q == LAST_STEP) begin
          st_d = ST_DONE;
        end
      end
      ST_DONE: begin
`ifdef NOEKEON_GAMMA_SKID_EN
        if (out_ready) begin
          if (buf_full_q) begin
            // Buffered state goes straight into processing, skipping IDLE.
            st_d     = ST_BUSY;
            load_buf = 1'b1;
          end else if (in_valid) begin
            // Buffer empty but a state arrives on the same edge: take it
            // directly so the buffer is never left full in IDLE.
            st_d    = ST_BUSY;
            load_in = 1'b1;
          end else begin
            st_d = ST_IDLE;
          end
        end else begin
          buf_push = in_valid && !buf_full_q;
        end
`else
        if (out_ready) begin
          st_d = ST_IDLE;
        end
`endif
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // State register and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      cnt_q   <= '0;
    end else if (load_in) begin
      state_q <= in_data;
      cnt_q   <= '0;
`ifdef NOEKEON_GAMMA_SKID_EN
    end else if (load_buf) begin
      state_q <= buf_q;
      cnt_q   <= '0;
`endif
    end else if (do_step) begin
      state_q <= step_data;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

`ifdef NOEKEON_GAMMA_SKID_EN
  // Input holding buffer: filled while the engine is occupied, drained when
  // the current result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else if (buf_push) begin
      buf_q      <= in_data;
      buf_full_q <= 1'b1;
    end else if (load_buf) begin
      buf_full_q <= 1'b0;
    end
  end

  assign in_ready = (st_q == ST_IDLE) || !buf_full_q;
`else
  assign in_ready = (st_q == ST_IDLE);
`endif

  assign out_valid = (st_q == ST_DONE);
  assign busy      = (st_q == ST_BUSY);
  assign out_data  = state_q;

endmodule
